shft_pipe: RTL and testbench

Parametrised, pipelined shifter/rotator for the datapath. It accepts one operation per cycle through a valid/ready handshake and returns the result after a fixed latency of `STAGES` cycles. It also returns a carry-out flag holding the last bit shifted or rotated out. It sits between operand fetch and writeback, beside the ALU, and replaces the single-cycle combinational shifter wherever a wider word or a shorter critical path is needed.

---
 rtl/shft_pipe.sv | 144 ++++++++++++++
 tb/tb_shft_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shft_pipe.sv
// Pipelined shifter/rotator with valid/ready handshake and carry-out of the last bit moved out.
// Define SHFT_PIPE_ROTATE_EN to implement ROL/ROR; otherwise those opcodes pass data through.
module shft_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned BPS     = (SHAMT_W + STAGES - 1) / STAGES;

  localparam logic [2:0] OP_LSHF  = 3'b000;
  localparam logic [2:0] OP_RSHFL = 3'b001;
  localparam logic [2:0] OP_RSHFA = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;

  // Partial shift by k; returns {carry, data}. Carry is meaningful only for k != 0.
  function automatic logic [WIDTH:0] apply_shift(input logic [WIDTH-1:0] x,
                                                 input logic [2:0] op,
                                                 input logic [SHAMT_W-1:0] k);
    logic [WIDTH-1:0]   r;
    logic [WIDTH-1:0]   t;
    logic               c;
    logic [SHAMT_W-1:0] km1;
    logic [SHAMT_W-1:0] nk;
    r   = x;
    t   = '0;
    c   = 1'b0;
    km1 = k - 1'b1;
    nk  = ~k + 1'b1;
    if (k != '0) begin
      case (op)
        OP_LSHF: begin
          r = x << k;
          t = x << km1;
          c = t[WIDTH-1];
        end
        OP_RSHFL: begin
          r = x >> k;
          t = x >> km1;
          c = t[0];
        end
        OP_RSHFA: begin
          r = $signed(x) >>> k;
          t = x >> km1;
          c = t[0];
        end
`ifdef SHFT_PIPE_ROTATE_EN
        OP_ROL: begin
          r = (x << k) | (x >> nk);
          c = r[0];
        end
        OP_ROR: begin
          r = (x >> k) | (x << nk);
          c = r[WIDTH-1];
        end
`endif
        default: begin
          r = x;
          c = 1'b0;
        end
      endcase
    end
    return {c, r};
  endfunction

  logic [WIDTH-1:0]   sd [STAGES];
  logic [SHAMT_W-1:0] sa [STAGES];
  logic [2:0]         so [STAGES];
  logic [STAGES-1:0]  sc;
  logic [STAGES-1:0]  sv;
  logic [STAGES-1:0]  adv;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // Amount bits owned by this stage, MSB-first; the last stage takes whatever remains.
    localparam int TOP  = int'(SHAMT_W) - i * int'(BPS);
    localparam int TOPC = (TOP < 0) ? 0 : TOP;
    localparam int LOW  = (i == int'(STAGES) - 1) ? 0 :
                          (((TOP - int'(BPS)) < 0) ? 0 : (TOP - int'(BPS)));
    localparam logic [SHAMT_W-1:0] MASK = SHAMT_W'(((1 << TOPC) - 1) & ~((1 << LOW) - 1));

    logic [WIDTH-1:0]   d_in;
    logic [SHAMT_W-1:0] a_in;
    logic [2:0]         o_in;
    logic               c_in;
    logic               v_in;
    logic [SHAMT_W-1:0] part;
    logic [WIDTH:0]     step;

    if (i == 0) begin : g_head
      assign d_in = in_data;
      assign a_in = in_amt;
      assign o_in = in_op;
      assign c_in = 1'b0;
      assign v_in = in_valid;
    end else begin : g_body
      assign d_in = sd[i-1];
      assign a_in = sa[i-1];
      assign o_in = so[i-1];
      assign c_in = sc[i-1];
      assign v_in = sv[i-1];
    end

    assign part   = a_in & MASK;
    assign step   = apply_shift(d_in, o_in, part);
    assign adv[i] = out_ready | ~(&sv[STAGES-1:i]);

    always_ff @(posedge clk) begin
      if (reset) begin
        sv[i] <= 1'b0;
        sc[i] <= 1'b0;
        sd[i] <= '0;
        sa[i] <= '0;
        so[i] <= '0;
      end else if (adv[i]) begin
        sv[i] <= v_in;
        if (v_in) begin
          sd[i] <= step[WIDTH-1:0];
          sa[i] <= a_in & ~MASK;
          so[i] <= o_in;
          sc[i] <= (part != '0) ? step[WIDTH] : c_in;
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = sv[STAGES-1];
  assign out_data  = sd[STAGES-1];
  assign out_carry = sc[STAGES-1];

endmodule

// File: tb/tb_shft_pipe.sv
// Directed self-checking bench for shft_pipe (WIDTH=16, STAGES=2).
module tb_shft_pipe;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 2;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  a;
    logic [2:0]  op;
    logic [15:0] ed;
    logic        ec;
  } vec_t;

`ifdef SHFT_PIPE_ROTATE_EN
  localparam logic [15:0] ROR_D = 16'h8000;
  localparam logic        ROR_C = 1'b1;
  localparam logic [15:0] ROL_D = 16'h0001;
  localparam logic        ROL_C = 1'b1;
  localparam logic [15:0] ROL6_D = 16'h0861;
  localparam logic        ROL6_C = 1'b1;
`else
  localparam logic [15:0] ROR_D = 16'h0001;
  localparam logic        ROR_C = 1'b0;
  localparam logic [15:0] ROL_D = 16'h8000;
  localparam logic        ROL_C = 1'b0;
  localparam logic [15:0] ROL6_D = 16'h8421;
  localparam logic        ROL6_C = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;

  int checks   = 0;
  int failures = 0;

  shft_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op into an empty pipe and observe its result (lat = -1 on timeout).
  task automatic run_single(input logic [15:0] d, input logic [3:0] a, input logic [2:0] op,
                            output logic [15:0] rd, output logic rc, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_op     = op;
    rd        = 'x;
    rc        = 1'bx;
    lat       = -1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (out_valid) begin
        lat = k;
        rd  = out_data;
        rc  = out_carry;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++;
    if (out_carry !== 1'b0) begin failures++; $display("FAIL reset_out_carry: got %b expected 0", out_carry); end
  endtask

  task automatic test_lshf();
    logic [15:0] rd;
    logic        rc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h00F1;
    in_amt    = 4'd4;
    in_op     = 3'b000;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL lshf_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL lshf_early_valid: got %b expected 0", out_valid); end
    tick();
    rd = out_data;
    rc = out_carry;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL lshf_valid_lat2: got %b expected 1", out_valid); end
    checks++;
    if (rd !== 16'h0F10) begin failures++; $display("FAIL lshf_data: got %h expected 0f10", rd); end
    checks++;
    if (rc !== 1'b0) begin failures++; $display("FAIL lshf_carry: got %b expected 0", rc); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL lshf_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_shift_variants();
    vec_t v [7];
    logic [15:0] rd;
    logic        rc;
    int          lat;
    v[0] = '{16'h8001, 4'd1,  3'b011, 16'hC000, 1'b1};
    v[1] = '{16'h8001, 4'd1,  3'b001, 16'h4000, 1'b1};
    v[2] = '{16'h0003, 4'd15, 3'b000, 16'h8000, 1'b1};
    v[3] = '{16'hA5A5, 4'd5,  3'b010, 16'hA5A5, 1'b0};
    v[4] = '{16'hF00F, 4'd0,  3'b001, 16'hF00F, 1'b0};
    v[5] = '{16'h0001, 4'd1,  3'b101, ROR_D,    ROR_C};
    v[6] = '{16'h8000, 4'd1,  3'b100, ROL_D,    ROL_C};
    for (int i = 0; i < 7; i++) begin
      run_single(v[i].d, v[i].a, v[i].op, rd, rc, lat);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL variant%0d_latency: got %0d expected 2", i, lat); end
      checks++;
      if ({rc, rd} !== {v[i].ec, v[i].ed}) begin
        failures++;
        $display("FAIL variant%0d_result: got c=%b d=%h expected c=%b d=%h", i, rc, rd, v[i].ec, v[i].ed);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t        ops [3];
    logic [16:0] got [$];
    int idx = 0, acc = 0, low = 0, unstable = 0;
    ops[0] = '{16'h0001, 4'd1, 3'b000, 16'h0002, 1'b0};
    ops[1] = '{16'h0180, 4'd8, 3'b001, 16'h0001, 1'b1};
    ops[2] = '{16'h8008, 4'd4, 3'b011, 16'hF800, 1'b1};
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = ops[idx].d;
      in_amt   = ops[idx].a;
      in_op    = ops[idx].op;
      if (in_ready) begin acc++; idx++; end
      else low++;
      if (c >= 2 && (out_valid !== 1'b1 || {out_carry, out_data} !== {ops[0].ec, ops[0].ed})) unstable++;
      tick();
    end
    checks++;
    if (acc != 2) begin failures++; $display("FAIL bp_accepted: got %0d expected 2", acc); end
    checks++;
    if (low != 3) begin failures++; $display("FAIL bp_in_ready_low_cycles: got %0d expected 3", low); end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL bp_output_stable: got %0d unstable cycles expected 0", unstable); end
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      if (idx < 3) begin
        in_valid = 1'b1;
        in_data  = ops[idx].d;
        in_amt   = ops[idx].a;
        in_op    = ops[idx].op;
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) got.push_back({out_carry, out_data});
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin failures++; $display("FAIL bp_result_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [16:0] g;
      g = (i < got.size()) ? got[i] : 17'bx;
      checks++;
      if (g !== {ops[i].ec, ops[i].ed}) begin
        failures++;
        $display("FAIL bp_order%0d: got %h expected %h", i, g, {ops[i].ec, ops[i].ed});
      end
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    in_amt    = 4'd2;
    in_op     = 3'b000;
    tick();
    in_data = 16'h2222;
    in_amt  = 4'd3;
    in_op   = 3'b001;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_data !== 16'h0000) begin failures++; $display("FAIL midreset_out_data: got %h expected 0000", out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midreset_stale_results: got %0d expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    vec_t        v [8];
    logic [16:0] got [$];
    int idx = 0, stalls = 0, first = -1, last = -1;
    v[0] = '{16'h1234, 4'd3,  3'b000, 16'h91A0, 1'b0};
    v[1] = '{16'hABCD, 4'd5,  3'b001, 16'h055E, 1'b0};
    v[2] = '{16'h9000, 4'd12, 3'b011, 16'hFFF9, 1'b0};
    v[3] = '{16'hC000, 4'd1,  3'b000, 16'h8000, 1'b1};
    v[4] = '{16'h7FFF, 4'd15, 3'b011, 16'h0000, 1'b1};
    v[5] = '{16'hBEEF, 4'd7,  3'b111, 16'hBEEF, 1'b0};
    v[6] = '{16'h8421, 4'd6,  3'b100, ROL6_D,   ROL6_C};
    v[7] = '{16'h5555, 4'd0,  3'b000, 16'h5555, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      if (idx < 8) begin
        in_valid = 1'b1;
        in_data  = v[idx].d;
        in_amt   = v[idx].a;
        in_op    = v[idx].op;
        if (in_ready) idx++;
        else stalls++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        got.push_back({out_carry, out_data});
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin failures++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
    checks++;
    if (got.size() != 8) begin failures++; $display("FAIL b2b_result_count: got %0d expected 8", got.size()); end
    checks++;
    if (last - first != 7) begin failures++; $display("FAIL b2b_consecutive: got span %0d expected 7", last - first); end
    for (int i = 0; i < 8; i++) begin
      logic [16:0] g;
      g = (i < got.size()) ? got[i] : 17'bx;
      checks++;
      if (g !== {v[i].ec, v[i].ed}) begin
        failures++;
        $display("FAIL b2b_result%0d: got %h expected %h", i, g, {v[i].ec, v[i].ed});
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    tick();
    test_reset();
    test_lshf();
    test_shift_variants();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
